// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller for a 5-stage RISC-V pipeline.
// Sequences the stage-register enables and flushes and the PC source.
// Handles three cases: load-use stalls, wrong-path squash on a taken branch,
// and freezing the pipeline while a multi-cycle data-memory access completes.
module pipeline_hazard_controller #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             ifid_uses_rs2,
  input  logic [4:0]       idex_rd,
  input  logic             idex_memread,
  input  logic             exmem_memread,
  input  logic             exmem_memwrite,
  input  logic             exmem_branch,
  input  logic             exmem_zero,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             memwb_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             pc_src,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  logic memop, taken, loaduse;
  logic freeze, eval_taken, eval_loaduse;

  assign memop   = exmem_memread | exmem_memwrite;
  assign taken   = exmem_branch & exmem_zero;
  assign loaduse = idex_memread && (idex_rd != 5'd0) &&
                   ((idex_rd == ifid_rs1) || (ifid_uses_rs2 && (idex_rd == ifid_rs2)));

  // Next-state, stage controls and counter updates, all from state and inputs.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d       = ST_RUN;
    dmem_req      = 1'b0;
    pc_write      = 1'b1;
    ifid_write    = 1'b1;
    idex_write    = 1'b1;
    exmem_write   = 1'b1;
    memwb_write   = 1'b1;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    exmem_flush   = 1'b0;
    pc_src        = 1'b0;
    freeze        = 1'b0;
    eval_taken    = 1'b0;
    eval_loaduse  = 1'b0;
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;

    unique case (state_q)
      ST_RUN: begin
        dmem_req = memop;
        if (memop && !dmem_ready) begin
          freeze  = 1'b1;
          state_d = ST_MEM_WAIT;
        end else begin
          eval_taken   = 1'b1;
          eval_loaduse = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        // Request stays up until memory signals completion.
        dmem_req = 1'b1;
        if (!dmem_ready) begin
          freeze  = 1'b1;
          state_d = ST_MEM_WAIT;
        end else begin
          eval_taken   = 1'b1;
          eval_loaduse = 1'b1;
        end
      end
      ST_FLUSH: begin
        // IF/ID and EX/MEM hold bubbles: no hazard evaluation, but a stray
        // memop is still honoured so the memory handshake never breaks.
        dmem_req = memop;
        if (memop && !dmem_ready) begin
          freeze  = 1'b1;
          state_d = ST_MEM_WAIT;
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (freeze) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      memwb_write = 1'b0;
    end else if (eval_taken && taken) begin
      // A taken branch squashes the wrong path; any load-use on it is moot.
      pc_src      = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      state_d     = ST_FLUSH;
      if (flush_count_q != '1) flush_count_d = flush_count_q + CNT_W'(1);
    end else if (eval_loaduse && loaduse) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end

    // One increment per frozen PC cycle, whatever the cause(s).
    if (!pc_write && (stall_count_q != '1)) stall_count_d = stall_count_q + CNT_W'(1);

    // Reset forces every control low combinationally, without waiting for an edge.
    if (!reset) begin
      dmem_req    = 1'b0;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      memwb_write = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      pc_src      = 1'b0;
    end
  end

  // State and performance-counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_RUN;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q       <= state_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign state       = state_q;
  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed testbench for pipeline_hazard_controller: reset, load-use stall,
// memory freeze, taken branch with flush, zero-wait store, reset in MEM_WAIT.
module tb_pipeline_hazard_controller;

  localparam int unsigned CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       ifid_rs1, ifid_rs2, idex_rd;
  logic             ifid_uses_rs2, idex_memread;
  logic             exmem_memread, exmem_memwrite, exmem_branch, exmem_zero;
  logic             dmem_ready;
  logic             dmem_req, pc_write, ifid_write, idex_write, exmem_write, memwb_write;
  logic             ifid_flush, idex_flush, exmem_flush, pc_src;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_count, flush_count;

  int errors = 0;
  int checks = 0;

  pipeline_hazard_controller #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_uses_rs2(ifid_uses_rs2),
    .idex_rd(idex_rd), .idex_memread(idex_memread),
    .exmem_memread(exmem_memread), .exmem_memwrite(exmem_memwrite),
    .exmem_branch(exmem_branch), .exmem_zero(exmem_zero),
    .dmem_ready(dmem_ready), .dmem_req(dmem_req),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
    .exmem_write(exmem_write), .memwb_write(memwb_write),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .pc_src(pc_src), .state(state),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifid_rs1 = 5'd0; ifid_rs2 = 5'd0; ifid_uses_rs2 = 1'b0;
    idex_rd = 5'd0; idex_memread = 1'b0;
    exmem_memread = 1'b0; exmem_memwrite = 1'b0;
    exmem_branch = 1'b0; exmem_zero = 1'b0; dmem_ready = 1'b0;
  endtask

  // Packs the five write enables as {pc,ifid,idex,exmem,memwb}.
  function automatic logic [31:0] wr();
    return {27'd0, pc_write, ifid_write, idex_write, exmem_write, memwb_write};
  endfunction

  function automatic logic [31:0] fl();
    return {29'd0, ifid_flush, idex_flush, exmem_flush};
  endfunction

  initial begin
    clear_inputs();
    reset = 1'b0;
    exmem_memread = 1'b1;          // memop during reset must not request
    #1;
    check("rst_writes", wr(), 32'h0);
    check("rst_req", {31'd0, dmem_req}, 32'd0);
    tick(); tick();
    check("rst_writes_2cyc", wr(), 32'h0);
    check("rst_flushes", fl(), 32'h0);
    check("rst_pc_src", {31'd0, pc_src}, 32'd0);
    clear_inputs();
    reset = 1'b1;
    #1;
    check("rel_state", {30'd0, state}, 32'd0);
    check("rel_stall", stall_count, 32'd0);
    check("rel_flush", flush_count, 32'd0);
    check("rel_writes", wr(), 32'h1f);
    check("rel_flushes", fl(), 32'h0);

    // Load-use on rs1.
    idex_memread = 1'b1; idex_rd = 5'd5; ifid_rs1 = 5'd5;
    #1;
    check("lu_writes", wr(), 32'h07);
    check("lu_flushes", fl(), 32'h2);
    tick();
    check("lu_stall", stall_count, 32'd1);
    check("lu_state", {30'd0, state}, 32'd0);
    // x0 never stalls.
    idex_rd = 5'd0; ifid_rs1 = 5'd0;
    #1;
    check("x0_writes", wr(), 32'h1f);
    tick();
    check("x0_stall", stall_count, 32'd1);
    // rs2 match ignored unless the instruction reads rs2.
    idex_rd = 5'd7; ifid_rs1 = 5'd1; ifid_rs2 = 5'd7; ifid_uses_rs2 = 1'b0;
    #1;
    check("rs2_unused", {31'd0, pc_write}, 32'd1);
    ifid_uses_rs2 = 1'b1;
    #1;
    check("rs2_used", {31'd0, pc_write}, 32'd0);
    tick();
    check("rs2_stall", stall_count, 32'd2);
    clear_inputs();

    // Load with three wait cycles.
    exmem_memread = 1'b1; dmem_ready = 1'b0;
    #1;
    check("mw_c1_req", {31'd0, dmem_req}, 32'd1);
    check("mw_c1_writes", wr(), 32'h0);
    check("mw_c1_state", {30'd0, state}, 32'd0);
    for (int i = 2; i <= 3; i++) begin
      tick();
      check($sformatf("mw_c%0d_state", i), {30'd0, state}, 32'd1);
      check($sformatf("mw_c%0d_req", i), {31'd0, dmem_req}, 32'd1);
      check($sformatf("mw_c%0d_writes", i), wr(), 32'h0);
    end
    tick();
    dmem_ready = 1'b1;
    #1;
    check("mw_rel_state", {30'd0, state}, 32'd1);
    check("mw_rel_req", {31'd0, dmem_req}, 32'd1);
    check("mw_rel_writes", wr(), 32'h1f);
    tick();
    clear_inputs();
    #1;
    check("mw_done_state", {30'd0, state}, 32'd0);
    check("mw_stall", stall_count, 32'd5);

    // Taken branch while a load-use is also present.
    exmem_branch = 1'b1; exmem_zero = 1'b1;
    idex_memread = 1'b1; idex_rd = 5'd3; ifid_rs1 = 5'd3;
    #1;
    check("br_pc_src", {31'd0, pc_src}, 32'd1);
    check("br_flushes", fl(), 32'h7);
    check("br_writes", wr(), 32'h1f);
    tick();
    exmem_branch = 1'b0; exmem_zero = 1'b0;
    #1;
    check("br_flush_cnt", flush_count, 32'd1);
    check("br_stall_cnt", stall_count, 32'd5);
    check("fl_state", {30'd0, state}, 32'd2);
    check("fl_lu_suppressed", wr(), 32'h1f);
    check("fl_pc_src", {31'd0, pc_src}, 32'd0);
    check("fl_flushes", fl(), 32'h0);
    tick();
    clear_inputs();
    #1;
    check("fl_back_state", {30'd0, state}, 32'd0);
    check("fl_back_stall", stall_count, 32'd5);

    // Zero-wait store.
    exmem_memwrite = 1'b1; dmem_ready = 1'b1;
    #1;
    check("st_req", {31'd0, dmem_req}, 32'd1);
    check("st_writes", wr(), 32'h1f);
    tick();
    clear_inputs();
    #1;
    check("st_state", {30'd0, state}, 32'd0);
    check("st_stall", stall_count, 32'd5);

    // Taken branch resolved in the MEM_WAIT release cycle.
    exmem_memread = 1'b1; exmem_branch = 1'b1; exmem_zero = 1'b1;
    #1;
    check("mwbr_freeze", wr(), 32'h0);
    tick();
    dmem_ready = 1'b1;
    #1;
    check("mwbr_pc_src", {31'd0, pc_src}, 32'd1);
    tick();
    clear_inputs();
    #1;
    check("mwbr_state", {30'd0, state}, 32'd2);
    check("mwbr_flush_cnt", flush_count, 32'd2);
    check("mwbr_stall", stall_count, 32'd6);
    tick();

    // Reset asserted mid MEM_WAIT.
    exmem_memread = 1'b1; dmem_ready = 1'b0;
    tick();
    check("rmw_state", {30'd0, state}, 32'd1);
    check("rmw_req", {31'd0, dmem_req}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("rmw_req_drop", {31'd0, dmem_req}, 32'd0);
    check("rmw_state_rst", {30'd0, state}, 32'd0);
    check("rmw_stall_rst", stall_count, 32'd0);
    clear_inputs();
    tick();
    reset = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
